// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - program-memory fetch handshake between sequencer and instruction memory
interface pc_sequencer_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction-fetch sequencer for the 8-bit core
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        imem,
    output logic [15:0]           prg,
    output logic                  exec_en,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  opw,
    input  logic [7:0]            tgt_lo,
    input  logic [7:0]            acc,
    input  logic                  jump,
    input  logic                  jumpr,
    input  logic                  page,
    input  logic                  page0,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_FETCH_TGT,
        S_HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        req;
    logic [7:0]  page_hi;

    // In EXEC the PC has already been incremented, so the page byte is that of the next word.
    assign page_hi   = page0 ? 8'h00 : pc[15:8];
    assign imem.req  = req;
    assign imem.addr = pc;
    // Execute strobe is purely state based; a stall simply withholds it.
    assign exec_en   = (state == S_EXEC) && !stall;

    // Sequencer FSM: request is registered so it never depends on the same-cycle ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_BOOT;
            pc     <= RESET_VEC;
            prg    <= 16'h0000;
            req    <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                    req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.ack) begin
                        prg   <= imem.data;
                        pc    <= pc + 16'd1;
                        req   <= 1'b0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else if (jumpr) begin
                            pc    <= {page_hi, acc};
                            req   <= 1'b1;
                            state <= S_FETCH;
                        end else if (jump && page) begin
                            pc    <= {page_hi, tgt_lo};
                            req   <= 1'b1;
                            state <= S_FETCH;
                        end else if (jump) begin
                            // PC already points at the absolute-target operand word.
                            req   <= 1'b1;
                            state <= S_FETCH_TGT;
                        end else if (opw) begin
                            pc    <= pc + 16'd1;
                            req   <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            req   <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH_TGT: begin
                    // Request stays high: the target fetch follows immediately.
                    if (imem.ack) begin
                        pc    <= imem.data;
                        state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    req    <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    req   <= 1'b0;
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with instruction-level reference model
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    logic [15:0] prg;
    logic        exec_en, halted, stall, opw, jump, jumpr, page, page0, halt;
    logic [7:0]  tgt_lo, acc;
    logic        halt_en;

    // Bench-side jump decoder: a fixed field layout of the instruction word.
    assign tgt_lo = prg[7:0];
    assign acc    = prg[7:0];
    assign page0  = prg[8];
    assign page   = prg[9];
    assign opw    = prg[10];
    assign jump   = prg[11];
    assign jumpr  = prg[12] & prg[13];
    assign halt   = halt_en && (prg[15:12] == 4'hF);

    pc_sequencer #(.RESET_VEC(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .imem    (bus),
        .prg     (prg),
        .exec_en (exec_en),
        .stall   (stall),
        .halt    (halt),
        .opw     (opw),
        .tgt_lo  (tgt_lo),
        .acc     (acc),
        .jump    (jump),
        .jumpr   (jumpr),
        .page    (page),
        .page0   (page0),
        .halted  (halted)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_prg[$];
    logic [15:0] fetch_log[$];
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic        ack_off = 1'b0;
    logic [15:0] m_addr;
    logic        m_tgt, m_halted;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        exp_addr.delete();
        exp_prg.delete();
        fetch_log.delete();
        m_addr   = 16'h0000;
        m_tgt    = 1'b0;
        m_halted = 1'b0;
        exp_addr.push_back(m_addr);
    endfunction

    // Instruction-level model: given the word at the expected address, where is the next fetch.
    function automatic void model_step();
        logic [15:0] w, nxt;
        logic [7:0]  hi;
        if (m_halted) return;
        if (m_tgt) begin
            m_addr = mem[m_addr];
            m_tgt  = 1'b0;
        end else begin
            w   = mem[m_addr];
            exp_prg.push_back(w);
            nxt = m_addr + 16'd1;
            hi  = w[8] ? 8'h00 : nxt[15:8];
            if (halt_en && w[15:12] == 4'hF) m_halted = 1'b1;
            else if (w[12] && w[13])          m_addr = {hi, w[7:0]};
            else if (w[11] && w[9])           m_addr = {hi, w[7:0]};
            else if (w[11]) begin             m_addr = nxt; m_tgt = 1'b1; end
            else if (w[10])                   m_addr = nxt + 16'd1;
            else                              m_addr = nxt;
        end
        if (!m_halted) exp_addr.push_back(m_addr);
    endfunction

    // Memory responder and stimulus driver; ack decisions feed the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        stall = ($urandom_range(0, 2) == 0);
        if (bus.req && !ack_off && $urandom_range(0, 99) < 50) begin
            bus.ack  = 1'b1;
            bus.data = mem[bus.addr];
            model_step();
        end else begin
            bus.ack  = 1'b0;
            bus.data = 16'($urandom);
        end
    endtask

    logic        p_valid = 1'b0;
    logic        p_req, p_ack, p_exec;
    logic [15:0] p_addr, p_prg;

    // Monitor: pops expectations whenever the DUT completes a fetch or strobes execute.
    always @(negedge clk) begin
        if (!mon_en) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid) begin
                if (p_req && !p_ack && bus.req) chk("addr_hold", {16'h0, bus.addr}, {16'h0, p_addr});
                if (!(p_req && p_ack))          chk("prg_hold", {16'h0, prg}, {16'h0, p_prg});
                if (p_exec)                     chk("exec_gap", {31'h0, exec_en}, 32'h0);
            end
            if (bus.req && bus.ack) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_unexpected actual=%h required=none", bus.addr);
                end else begin
                    chk("fetch_addr", {16'h0, bus.addr}, {16'h0, exp_addr.pop_front()});
                end
                fetch_log.push_back(bus.addr);
            end
            if (exec_en) begin
                if (exp_prg.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL exec_unexpected actual=%h required=none", prg);
                end else begin
                    chk("exec_prg", {16'h0, prg}, {16'h0, exp_prg.pop_front()});
                end
            end
            if (halted) begin
                chk("halted_req", {31'h0, bus.req}, 32'h0);
                chk("halted_exec", {31'h0, exec_en}, 32'h0);
            end
            p_valid = 1'b1;
            p_req   = bus.req;
            p_ack   = bus.ack;
            p_exec  = exec_en;
            p_addr  = bus.addr;
            p_prg   = prg;
        end
    end

    logic [15:0] gold [15];

    initial begin
        bus.ack  = 1'b0;
        bus.data = 16'h0000;
        stall    = 1'b0;
        halt_en  = 1'b1;
        gold = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h1233, 16'h1240, 16'h0040,
                 16'h0041, 16'h0010, 16'h0011, 16'hBEEF, 16'hBEF1, 16'hBEF2, 16'h20FE, 16'h207F};

        // Directed program: NOPs, long jump, page jumps, opw skip, JUMPR over JUMP, halt.
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0002] = 16'h0800;  mem[16'h0003] = 16'h1233;
        mem[16'h1233] = 16'h0A40;
        mem[16'h1240] = 16'h0B40;
        mem[16'h0040] = 16'h0800;  mem[16'h0041] = 16'h0010;
        mem[16'h0010] = 16'h0800;  mem[16'h0011] = 16'hBEEF;
        mem[16'hBEEF] = 16'h0400;
        mem[16'hBEF1] = 16'h0800;  mem[16'hBEF2] = 16'h20FE;
        mem[16'h20FE] = 16'h387F;
        mem[16'h207F] = 16'hF000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, bus.req}, 32'h0);
        chk("rst_exec", {31'h0, exec_en}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_prg", {16'h0, prg}, 32'h0);
        chk("rst_addr", {16'h0, bus.addr}, 32'h0);
        model_reset();
        mon_en = 1'b1;
        rst    = 1'b0;
        begin
            int n = 0;
            while (!halted && n < 3000) begin
                cycle();
                n++;
            end
        end
        chk("halt_reached", {31'h0, halted}, 32'h1);
        repeat (4) cycle();
        chk("halt_req_low", {31'h0, bus.req}, 32'h0);
        chk("exp_addr_drained", exp_addr.size(), 32'h0);
        chk("exp_prg_drained", exp_prg.size(), 32'h0);
        chk("log_len", fetch_log.size(), 32'd15);
        for (int i = 0; i < 15; i++) begin
            if (i < fetch_log.size()) chk("directed_addr", {16'h0, fetch_log[i]}, {16'h0, gold[i]});
        end

        // Random program: reset leaves HALTED, then long free run.
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        chk("rehalt_cleared", {31'h0, halted}, 32'h0);
        chk("rehalt_req", {31'h0, bus.req}, 32'h0);
        halt_en = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        model_reset();
        mon_en = 1'b1;
        rst    = 1'b0;
        repeat (3000) cycle();
        chk("random_progress", {31'h0, fetch_log.size() > 500}, 32'h1);

        // Reset while a fetch request is outstanding.
        ack_off = 1'b1;
        begin
            int n = 0;
            while (!bus.req && n < 20) begin
                cycle();
                n++;
            end
        end
        chk("mid_req_seen", {31'h0, bus.req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'h0, bus.req}, 32'h0);
        chk("rst_mid_addr", {16'h0, bus.addr}, 32'h0);
        mon_en  = 1'b0;
        ack_off = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;
        rst    = 1'b0;
        begin
            int n = 0;
            while (fetch_log.size() == 0 && n < 50) begin
                cycle();
                n++;
            end
        end
        chk("post_rst_fetch_seen", {31'h0, fetch_log.size() > 0}, 32'h1);
        if (fetch_log.size() > 0) chk("post_rst_first_addr", {16'h0, fetch_log[0]}, 32'h0);
        repeat (20) cycle();
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
